// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
// Scan controller in front of an 8-bit SAR ADC core. It steps the analog mux
// through every enabled channel. For each channel it waits for the mux to
// settle, runs one SAR conversion (with a timeout), then stores the result and
// compares it against a threshold.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start, continuous   scan request (IDLE only); auto-restart at scan end
//   ch_mask             enabled channels, latched on an accepted start
//   thresh, alarm_clr   alarm threshold (sampled in CAPTURE); alarm clear
//   adc_done, adc_data  SAR completion flag and result
//   rd_addr, rd_data    combinational result read port (0 beyond NUM_CH)
//   adc_enable, mux_sel SAR enable and analog mux select
//   busy, scan_done     not-IDLE flag; one-cycle pulse in the last NEXT
//   result_valid        per-channel "stored this scan"
//   alarm, timeout_err  sticky per-channel alarm; sticky conversion timeout
module adc_scan_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [7:0]        thresh,
    input  logic              alarm_clr,
    input  logic              adc_done,
    input  logic [7:0]        adc_data,
    input  logic [CH_W-1:0]   rd_addr,
    output logic              adc_enable,
    output logic [CH_W-1:0]   mux_sel,
    output logic              busy,
    output logic              scan_done,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] result_valid,
    output logic [NUM_CH-1:0] alarm,
    output logic              timeout_err
);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CONVERT, S_CAPTURE, S_NEXT} state_t;

    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_CH-1:0]       mask_q;
    logic [NUM_CH-1:0][7:0]  result;

    logic [CH_W-1:0]         start_idx;  // lowest set bit of ch_mask
    logic [CH_W-1:0]         first_idx;  // lowest set bit of the latched mask
    logic [CH_W-1:0]         nxt_idx;    // next set bit above mux_sel
    logic                    has_nxt;

    // Priority scans run high to low, so the last match wins and gives the
    // lowest qualifying index.
    always_comb begin
        start_idx = '0;
        first_idx = '0;
        nxt_idx   = '0;
        has_nxt   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) start_idx = CH_W'(i);
            if (mask_q[i])  first_idx = CH_W'(i);
            if (mask_q[i] && (i > int'(mux_sel))) begin
                nxt_idx = CH_W'(i);
                has_nxt = 1'b1;
            end
        end
    end

    // Addresses at or beyond NUM_CH match no entry and read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (rd_addr == CH_W'(i)) rd_data = result[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            mask_q       <= '0;
            result       <= '0;
            adc_enable   <= 1'b0;
            mux_sel      <= '0;
            busy         <= 1'b0;
            scan_done    <= 1'b0;
            result_valid <= '0;
            alarm        <= '0;
            timeout_err  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            // A set from CAPTURE below overrides this clear for its channel.
            if (alarm_clr) alarm <= '0;
            case (state)
                S_IDLE: begin
                    if (start && (|ch_mask)) begin
                        mask_q       <= ch_mask;
                        result_valid <= '0;
                        timeout_err  <= 1'b0;
                        mux_sel      <= start_idx;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt        <= '0;
                        adc_enable <= 1'b1;
                        state      <= S_CONVERT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CONVERT: begin
                    if (adc_done) begin
                        adc_enable <= 1'b0;
                        state      <= S_CAPTURE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abandon this channel; its result and valid bit stay as they were.
                        adc_enable  <= 1'b0;
                        timeout_err <= 1'b1;
                        scan_done   <= ~has_nxt;
                        state       <= S_NEXT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (mux_sel == CH_W'(i)) begin
                            result[i]       <= adc_data;
                            result_valid[i] <= 1'b1;
                            if (adc_data > thresh) alarm[i] <= 1'b1;
                        end
                    end
                    // Registered so that the pulse lines up with the NEXT cycle.
                    scan_done <= ~has_nxt;
                    state     <= S_NEXT;
                end
                S_NEXT: begin
                    cnt <= '0;
                    if (has_nxt) begin
                        mux_sel <= nxt_idx;
                        state   <= S_SETTLE;
                    end else if (continuous) begin
                        mux_sel      <= first_idx;
                        result_valid <= '0;
                        state        <= S_SETTLE;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    adc_enable <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
